// File: rtl/nibble_serial_subtractor_pkg.sv
// Shared types and constants for the nibble-serial 32-bit subtractor.
// One 4-bit borrow look-ahead slice is reused for every nibble.
package sub_pkg;

    localparam int NIB_W   = 4;
    localparam int DATA_W  = 32;
    localparam int CNT_W   = 3;
    localparam int NIBBLES = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

endpackage

// File: rtl/nibble_serial_subtractor_if.sv
// Start/done handshake and operand/result bus of the nibble-serial subtractor.
// The master drives requests; the slave is the subtractor.
interface nibble_serial_subtractor_if;
    import sub_pkg::*;

    logic              inp_start;
    logic [DATA_W-1:0] inp_A;
    logic [DATA_W-1:0] inp_B;
    logic              inp_bin;
    logic [DATA_W-1:0] out_D;
    logic              out_bout;
    logic              out_zero;
    logic              out_ovf;
    logic              out_busy;
    logic              out_done;

    modport master (
        output inp_start, inp_A, inp_B, inp_bin,
        input  out_D, out_bout, out_zero, out_ovf, out_busy, out_done
    );

    modport slave (
        input  inp_start, inp_A, inp_B, inp_bin,
        output out_D, out_bout, out_zero, out_ovf, out_busy, out_done
    );

endinterface

// File: rtl/nibble_serial_subtractor_borrow.sv
// Combinational 4-bit borrow look-ahead subtract slice: d = a - b - bin.
// b3_in is the borrow into bit 3, needed upstream for signed overflow.
module nibble_borrow_lookahead
    import sub_pkg::*;
(
    input  logic [NIB_W-1:0] a,
    input  logic [NIB_W-1:0] b,
    input  logic             bin,
    output logic [NIB_W-1:0] d,
    output logic             bout,
    output logic             b3_in
);

    logic [NIB_W-1:0] g_s;
    logic [NIB_W-1:0] p_s;
    logic [NIB_W:0]   c_s;

    // Generate when a=0,b=1; propagate an incoming borrow when a==b.
    assign g_s = ~a & b;
    assign p_s = ~(a ^ b);

    assign c_s[0] = bin;
    assign c_s[1] = g_s[0] | (p_s[0] & bin);
    assign c_s[2] = g_s[1] | (p_s[1] & g_s[0]) | (p_s[1] & p_s[0] & bin);
    assign c_s[3] = g_s[2] | (p_s[2] & g_s[1]) | (p_s[2] & p_s[1] & g_s[0])
                  | (p_s[2] & p_s[1] & p_s[0] & bin);
    assign c_s[4] = g_s[3] | (p_s[3] & g_s[2]) | (p_s[3] & p_s[2] & g_s[1])
                  | (p_s[3] & p_s[2] & p_s[1] & g_s[0])
                  | (p_s[3] & p_s[2] & p_s[1] & p_s[0] & bin);

    assign d     = a ^ b ^ c_s[NIB_W-1:0];
    assign bout  = c_s[4];
    assign b3_in = c_s[3];

endmodule

// File: rtl/nibble_serial_subtractor.sv
// 32-bit subtractor D = A - B - bin, one nibble per clock, LSB nibble first.
// Result flags update only on the final nibble; they hold otherwise.
module nibble_serial_subtractor
    import sub_pkg::*;
#(
    parameter int NIBBLES_P = NIBBLES
) (
    input  logic                      inp_clk,
    input  logic                      inp_rst,
    nibble_serial_subtractor_if.slave bus
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(NIBBLES_P - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = 3'd1;

    state_e            state_q, state_d;
    logic [DATA_W-1:0] a_q, a_d;
    logic [DATA_W-1:0] b_q, b_d;
    logic [DATA_W-1:0] res_q, res_d;
    logic              borrow_q, borrow_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [DATA_W-1:0] dout_q, dout_d;
    logic              bout_q, bout_d;
    logic              zero_q, zero_d;
    logic              ovf_q, ovf_d;

    logic [NIB_W-1:0]  slice_a_s;
    logic [NIB_W-1:0]  slice_b_s;
    logic [NIB_W-1:0]  slice_d_s;
    logic              slice_bout_s;
    logic              slice_b3_s;

    assign slice_a_s = a_q[{cnt_q, 2'b00} +: NIB_W];
    assign slice_b_s = b_q[{cnt_q, 2'b00} +: NIB_W];

    nibble_borrow_lookahead u_slice (
        .a     (slice_a_s),
        .b     (slice_b_s),
        .bin   (borrow_q),
        .d     (slice_d_s),
        .bout  (slice_bout_s),
        .b3_in (slice_b3_s)
    );

    // Next-state and datapath update for the IDLE/RUN/DONE sequencer.
    always_comb begin
        state_d  = state_q;
        a_d      = a_q;
        b_d      = b_q;
        res_d    = res_q;
        borrow_d = borrow_q;
        cnt_d    = cnt_q;
        dout_d   = dout_q;
        bout_d   = bout_q;
        zero_d   = zero_q;
        ovf_d    = ovf_q;
        case (state_q)
            IDLE: begin
                if (bus.inp_start) begin
                    state_d  = RUN;
                    a_d      = bus.inp_A;
                    b_d      = bus.inp_B;
                    borrow_d = bus.inp_bin;
                    cnt_d    = {CNT_W{1'b0}};
                end else begin
                    state_d = IDLE;
                end
            end
            RUN: begin
                res_d[{cnt_q, 2'b00} +: NIB_W] = slice_d_s;
                borrow_d = slice_bout_s;
                cnt_d    = cnt_q + CNT_ONE;
                if (cnt_q == CNT_LAST) begin
                    state_d = DONE;
                    dout_d  = res_d;
                    bout_d  = slice_bout_s;
                    zero_d  = (res_d == {DATA_W{1'b0}});
                    ovf_d   = slice_b3_s ^ slice_bout_s;
                end else begin
                    state_d = RUN;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers; reset clears everything, aborting any operation.
    always_ff @(posedge inp_clk or posedge inp_rst) begin
        if (inp_rst) begin
            state_q  <= IDLE;
            a_q      <= {DATA_W{1'b0}};
            b_q      <= {DATA_W{1'b0}};
            res_q    <= {DATA_W{1'b0}};
            borrow_q <= 1'b0;
            cnt_q    <= {CNT_W{1'b0}};
            dout_q   <= {DATA_W{1'b0}};
            bout_q   <= 1'b0;
            zero_q   <= 1'b0;
            ovf_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            a_q      <= a_d;
            b_q      <= b_d;
            res_q    <= res_d;
            borrow_q <= borrow_d;
            cnt_q    <= cnt_d;
            dout_q   <= dout_d;
            bout_q   <= bout_d;
            zero_q   <= zero_d;
            ovf_q    <= ovf_d;
        end
    end

    assign bus.out_D    = dout_q;
    assign bus.out_bout = bout_q;
    assign bus.out_zero = zero_q;
    assign bus.out_ovf  = ovf_q;
    assign bus.out_busy = (state_q != IDLE);
    assign bus.out_done = (state_q == DONE);

endmodule
